// File: rtl/fft_bin_streamer.sv
// fft_bin_streamer: captures one FFT output frame as per-bin magnitudes into RAM,
// then replays it as an index/magnitude stream for the measurement block.
module fft_bin_streamer #(
    parameter int N_PTS   = 4096,
    parameter int ADDR_W  = 12,
    parameter int IDX_W   = 13,
    parameter int DATA_W  = 16,
    parameter int GAP_CYC = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fft_valid,
    input  logic                     fft_sop,
    input  logic                     fft_eop,
    input  logic signed [DATA_W-1:0] fft_real,
    input  logic signed [DATA_W-1:0] fft_imag,
    input  logic [5:0]               fft_exp,
    output logic                     fft_ready,
    output logic [IDX_W-1:0]         idx_out,
    output logic [16:0]              mag_out,
    output logic [5:0]               exp_out,
    output logic                     out_valid,
    output logic                     frame_done,
    output logic                     frame_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CAP  = 2'd1;
    localparam logic [1:0] S_PLAY = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;
    localparam int GCNT_W = $clog2(GAP_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_PTS - 1);

    // |v| with the most negative code clamped to the most positive one
    function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] v);
        if (v == {1'b1, {(DATA_W-1){1'b0}}}) return {1'b0, {(DATA_W-1){1'b1}}};
        else if (v[DATA_W-1])                 return DATA_W'(-v);
        else                                  return DATA_W'(v);
    endfunction

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
    logic [2:0]        vld_pipe_q;      // [0] raddr valid, [1] RAM data valid, [2] output valid
    logic              vld0_d;
    logic [5:0]        exp_q, exp_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              ready_q;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic              acc;

    logic [DATA_W-1:0] a_abs, b_abs, mx, mn;
    logic [16:0]       mag_c;

    logic [16:0]       ram [N_PTS];
    logic [16:0]       rdata_q;
    logic [ADDR_W-1:0] idx1_q;
    logic [IDX_W-1:0]  idx_out_q;
    logic [16:0]       mag_out_q;

    assign acc = fft_valid && ready_q;

    // alpha-max-plus-beta-min magnitude of the incoming beat
    always_comb begin
        a_abs = abs_sat(fft_real);
        b_abs = abs_sat(fft_imag);
        mx    = (a_abs > b_abs) ? a_abs : b_abs;
        mn    = (a_abs > b_abs) ? b_abs : a_abs;
        mag_c = 17'(mx) + 17'(mn >> 2) + 17'(mn >> 3);
    end

    // capture / playback / gap sequencing
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        raddr_d = raddr_q;
        gcnt_d  = gcnt_q;
        vld0_d  = vld_pipe_q[0];
        exp_d   = exp_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        we      = 1'b0;
        waddr   = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (acc && fft_sop) begin
                    we      = 1'b1;
                    waddr   = '0;
                    wcnt_d  = ADDR_W'(1);
                    state_d = S_CAP;
                end
            end
            S_CAP: begin
                if (acc) begin
                    if (fft_sop) begin
                        // a sop inside a frame kills the frame and is itself dropped
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (wcnt_q == LAST_BIN) begin
                        if (fft_eop) begin
                            we      = 1'b1;
                            exp_d   = fft_exp;
                            raddr_d = '0;
                            vld0_d  = 1'b1;
                            state_d = S_PLAY;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (fft_eop) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        we     = 1'b1;
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (vld_pipe_q[0]) begin
                    raddr_d = raddr_q + 1'b1;
                    if (raddr_q == LAST_BIN) vld0_d = 1'b0;
                end else if (!vld_pipe_q[1]) begin
                    // last bin sits in the output register now; next cycle is the gap
                    gcnt_d  = '0;
                    done_d  = 1'b1;
                    state_d = S_GAP;
                end
            end
            default: begin
                gcnt_d = gcnt_q + 1'b1;
                if (gcnt_q == GCNT_W'(GAP_CYC - 1)) state_d = S_IDLE;
            end
        endcase
    end

    // control state, status pulses and registered ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            raddr_q    <= '0;
            gcnt_q     <= '0;
            vld_pipe_q <= '0;
            exp_q      <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            raddr_q    <= raddr_d;
            gcnt_q     <= gcnt_d;
            vld_pipe_q <= {vld_pipe_q[1:0], vld0_d};
            exp_q      <= exp_d;
            err_q      <= err_d;
            done_q     <= done_d;
            ready_q    <= (state_d == S_IDLE) || (state_d == S_CAP);
        end
    end

    // frame RAM: write on accepted beat, registered read
    always_ff @(posedge clk) begin
        if (we) ram[waddr] <= mag_c;
        rdata_q <= ram[raddr_q];
    end

    // read-address delay matching the RAM latency, then the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            idx1_q    <= '0;
            idx_out_q <= '0;
            mag_out_q <= '0;
        end else begin
            idx1_q <= raddr_q;
            if (vld_pipe_q[1]) begin
                idx_out_q <= IDX_W'(idx1_q);
                mag_out_q <= rdata_q;
            end else begin
                idx_out_q <= '0;
                mag_out_q <= '0;
            end
        end
    end

    assign fft_ready  = ready_q;
    assign idx_out    = idx_out_q;
    assign mag_out    = mag_out_q;
    assign exp_out    = exp_q;
    assign out_valid  = vld_pipe_q[2];
    assign frame_done = done_q;
    assign frame_err  = err_q;
endmodule

// File: tb/tb_fft_bin_streamer.sv
// Scoreboard bench for fft_bin_streamer: driver pushes expected replay bins,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_fft_bin_streamer;
    localparam int N = 4096;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               fft_valid = 1'b0, fft_sop = 1'b0, fft_eop = 1'b0;
    logic signed [15:0] fft_real = '0, fft_imag = '0;
    logic [5:0]         fft_exp = '0;
    logic               fft_ready, out_valid, frame_done, frame_err;
    logic [12:0]        idx_out;
    logic [16:0]        mag_out;
    logic [5:0]         exp_out;

    fft_bin_streamer dut (
        .clk(clk), .rst(rst), .fft_valid(fft_valid), .fft_sop(fft_sop), .fft_eop(fft_eop),
        .fft_real(fft_real), .fft_imag(fft_imag), .fft_exp(fft_exp), .fft_ready(fft_ready),
        .idx_out(idx_out), .mag_out(mag_out), .exp_out(exp_out), .out_valid(out_valid),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; int mag; int ex; } exp_t;
    exp_t sb[$];

    int n_chk = 0, n_pass = 0, n_done = 0, n_err = 0, n_print = 0;
    bit abort = 0;
    bit last_full = 0, prev_valid = 0;
    int prev_idx = 0;

    task automatic check(string name, longint act, longint req);
        n_chk++;
        if (act == req) n_pass++;
        else if (n_print < 40) begin
            n_print++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int mag_ref(int re, int im);
        int a, b, mx, mn;
        a = (re < 0) ? -re : re;
        b = (im < 0) ? -im : im;
        if (a > 32767) a = 32767;
        if (b > 32767) b = 32767;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return mx + mn / 4 + mn / 8;
    endfunction

    // frame patterns: 0 = sparse directed frame, 1..3 = ramps
    function automatic void pat(int kind, int k, output int re, output int im);
        re = 0; im = 0;
        case (kind)
            0: begin
                if (k == 100)    begin re = 1000;   im = -400;   end
                else if (k == 5) begin re = -32768; im = -32768; end
                else if (k == 6) begin re = 0;      im = -32768; end
            end
            1: begin re = k * 8 - 16384; im = 3 * k - 6000;  end
            2: begin re = -k * 5;        im = k * 7 - 20000; end
            default: begin re = k;       im = -k;            end
        endcase
    endfunction

    function automatic int exp_mag(int kind, int k);
        int re, im;
        if (kind == 0) begin
            case (k)
                100:     return 1150;    // 1000 + 400/4 + 400/8
                5:       return 45053;   // 32767 + 8191 + 4095
                6:       return 32767;
                default: return 0;
            endcase
        end
        pat(kind, k, re, im);
        return mag_ref(re, im);
    endfunction

    // call at a negedge; returns at the negedge after the beat is accepted
    task automatic send_beat(int re, int im, bit sop, bit eop, int ex);
        int t = 0;
        if (abort) return;
        fft_valid = 1'b1; fft_real = 16'(re); fft_imag = 16'(im);
        fft_sop = sop; fft_eop = eop; fft_exp = 6'(ex);
        while (!fft_ready && t < 10000) begin @(negedge clk); t++; end
        if (!fft_ready) begin
            n_chk++;
            $display("FAIL ready_timeout: fft_ready stayed 0, expected 1");
            abort = 1;
            return;
        end
        @(negedge clk);
    endtask

    task automatic send_frame(int kind, int ex, int last_bin, bit good);
        int re, im;
        for (int k = 0; k <= last_bin; k++) begin
            pat(kind, k, re, im);
            send_beat(re, im, k == 0, k == last_bin, ex);
        end
        if (good) for (int k = 0; k < N; k++) sb.push_back('{k, exp_mag(kind, k), ex});
    endtask

    task automatic wait_done(int target);
        int t = 0;
        while (n_done < target && t < 20000) begin @(negedge clk); t++; end
        check("frame_done_count", n_done, target);
    endtask

    // monitor: scoreboard pops, idle-zero, contiguity and frame_done alignment
    always @(negedge clk) begin
        if (rst) begin
            last_full  = 0;
            prev_valid = 0;
        end else begin
            if (frame_err) n_err++;
            if (frame_done) n_done++;
            if (frame_done || last_full) check("frame_done_align", frame_done, last_full);
            if (frame_done) check("ready_low_in_gap", fft_ready, 0);
            if (prev_valid && prev_idx != N - 1)
                check("contiguous_idx", out_valid ? idx_out : -1, prev_idx + 1);
            if (out_valid) begin
                check("ready_low_in_play", fft_ready, 0);
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_output: idx %0d with empty scoreboard", idx_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("idx_out", idx_out, e.idx);
                    check("mag_out", mag_out, e.mag);
                    check("exp_out", exp_out, e.ex);
                end
            end else begin
                check("idle_zero", {idx_out, mag_out}, 0);
            end
            last_full  = out_valid && (idx_out == 13'(N - 1));
            prev_valid = out_valid;
            prev_idx   = idx_out;
        end
    end

    initial begin
        int t;
        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", fft_ready, 0);
        check("rst_outs", {idx_out, mag_out, exp_out, out_valid, frame_done, frame_err}, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", fft_ready, 1);

        // directed sparse frame with saturation bins
        send_frame(0, 54, N - 1, 1);
        fft_valid = 1'b0;
        wait_done(1);
        repeat (3) @(negedge clk);

        // early eop at bin 2000
        send_frame(1, 7, 2000, 0);
        fft_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("early_eop_err", n_err, 1);
        for (int i = 0; i < 4; i++) begin
            check("ready_after_err", fft_ready, 1);
            @(negedge clk);
        end

        // back-to-back frames, fft_valid held high across the gap
        send_frame(1, 17, N - 1, 1);
        send_frame(2, 33, N - 1, 1);
        fft_valid = 1'b0;
        wait_done(3);
        repeat (3) @(negedge clk);

        // reset during playback at bin 3000
        send_frame(3, 9, N - 1, 1);
        fft_valid = 1'b0;
        t = 0;
        while (!(out_valid && idx_out == 13'd3000) && t < 10000) begin @(negedge clk); t++; end
        check("reached_bin_3000", idx_out, 3000);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_idx", idx_out, 0);
        check("abort_valid", out_valid, 0);
        check("abort_exp", exp_out, 0);
        check("abort_done", frame_done, 0);
        check("abort_sb_left", sb.size(), N - 3001);
        sb.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        check("final_done_count", n_done, 3);
        check("final_err_count", n_err, 1);
        check("ready_idle_end", fft_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
